// File: rtl/phase_seq_pkg.sv
// Shared types for the phase sequencer.
// Sub-state encoding and error-code constants.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_START,
    RUN,
    DONE,
    ERROR
  } sub_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;

endpackage

// File: rtl/phase_watchdog.sv
// Shared per-phase watchdog: clear/enable counter.
// Ports: clock, reset_n, clear, enable -> limit.
module phase_watchdog #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic limit
);

  // limit flags the edge on which the count would
  // reach TIMEOUT_CYCLES, i.e. the last allowed cycle
  localparam int unsigned LAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign limit = (TIMEOUT_CYCLES > 0) && enable &&
                 (count == CNT_W'(LAST));

endmodule

// File: rtl/phase_sequencer.sv
// Sequences NUM_PHASES ordered phases with handshakes.
// Ports: restart, start_req, end_done -> grant, leds,
//        status, busy, done, error, err_code.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES     = 3,
  parameter int unsigned IDX_W          = $clog2(NUM_PHASES + 1),
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter bit          AUTO_START0    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic [NUM_PHASES-1:0] start_req,
  input  logic [NUM_PHASES-1:0] end_done,
  output logic [NUM_PHASES-1:0] grant,
  output logic [NUM_PHASES:0]   leds,
  output logic [IDX_W-1:0]      status,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  function automatic logic [NUM_PHASES-1:0] above(
    input logic [IDX_W-1:0] idx
  );
    logic [NUM_PHASES-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_PHASES; j++)
      m[j] = (j > int'(idx));
    return m;
  endfunction

  function automatic logic [NUM_PHASES-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    logic [NUM_PHASES-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_PHASES; j++)
      m[j] = (j == int'(idx));
    return m;
  endfunction

  function automatic logic [NUM_PHASES:0] therm(
    input logic [IDX_W-1:0] idx
  );
    logic [NUM_PHASES:0] m;
    m = '0;
    for (int j = 0; j <= NUM_PHASES; j++)
      m[j] = (j <= int'(idx));
    return m;
  endfunction

  // Returns 0 for an index past the last phase
  function automatic logic pick(
    input logic [NUM_PHASES-1:0] vec,
    input logic [IDX_W-1:0]      idx
  );
    logic r;
    r = 1'b0;
    for (int j = 0; j < NUM_PHASES; j++)
      if (j == int'(idx)) r = vec[j];
    return r;
  endfunction

  sub_state_t            state, state_n;
  logic [NUM_PHASES-1:0] pending, pending_n;
  logic [NUM_PHASES-1:0] grant_n;
  logic [NUM_PHASES:0]   leds_n;
  logic [IDX_W-1:0]      status_n, nxt;
  logic                  busy_n, done_n, error_n;
  logic [1:0]            err_n;
  logic                  wd_clear, wd_en, wd_limit;
  logic                  viol, go;

  phase_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wd (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_en),
    .limit   (wd_limit)
  );

  always_comb begin
    state_n   = state;
    status_n  = status;
    grant_n   = grant;
    busy_n    = busy;
    done_n    = done;
    error_n   = error;
    err_n     = err_code;
    pending_n = pending;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    nxt       = status + IDX_W'(1);
    viol      = |(end_done & above(status));
    go        = pick(start_req, status) |
                pick(pending, status) |
                (AUTO_START0 && status == '0);

    if (restart) begin
      state_n   = WAIT_START;
      status_n  = '0;
      grant_n   = '0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      error_n   = 1'b0;
      err_n     = ERR_NONE;
      pending_n = '0;
      wd_clear  = 1'b1;
    end else begin
      unique case (state)
        WAIT_START: begin
          pending_n = pending |
                      (start_req & above(status));
          if (viol) begin
            state_n = ERROR;
            error_n = 1'b1;
            err_n   = ERR_ORDER;
          end else if (go) begin
            state_n   = RUN;
            grant_n   = onehot(status);
            busy_n    = 1'b1;
            pending_n = pending_n & ~onehot(status);
            wd_clear  = 1'b1;
          end
        end
        RUN: begin
          wd_en     = 1'b1;
          pending_n = pending |
                      (start_req & above(status));
          // order fault beats completion, which beats timeout
          if (viol) begin
            state_n = ERROR;
            grant_n = '0;
            busy_n  = 1'b0;
            error_n = 1'b1;
            err_n   = ERR_ORDER;
          end else if (pick(end_done, status)) begin
            status_n = nxt;
            if (nxt == IDX_W'(NUM_PHASES)) begin
              state_n = DONE;
              grant_n = '0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else if (pick(pending, nxt) ||
                         pick(start_req, nxt)) begin
              state_n   = RUN;
              grant_n   = onehot(nxt);
              pending_n = pending_n & ~onehot(nxt);
              wd_clear  = 1'b1;
            end else begin
              state_n = WAIT_START;
              grant_n = '0;
              busy_n  = 1'b0;
            end
          end else if (wd_limit) begin
            state_n = ERROR;
            grant_n = '0;
            busy_n  = 1'b0;
            error_n = 1'b1;
            err_n   = ERR_TIMEOUT;
          end
        end
        DONE, ERROR: begin
        end
      endcase
    end

    leds_n = therm(status_n);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_START;
      status   <= '0;
      grant    <= '0;
      leds     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      pending  <= '0;
    end else begin
      state    <= state_n;
      status   <= status_n;
      grant    <= grant_n;
      leds     <= leds_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
      err_code <= err_n;
      pending  <= pending_n;
    end
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor to the receive/process/transmit main controller. It sequences NUM_PHASES ordered phases. Each phase has a start/end handshake, sticky early-start latching, a per-phase watchdog timeout and protocol-order checking. It drives grant lines, a thermometer progress display and a status index. It sits at the top of the datapath, gating the receiver, processor and transmitter blocks.

Parameters:
NUM_PHASES, 3, number of sequenced phases (phase 0 = receive).
IDX_W, $clog2(NUM_PHASES+1), width of the phase index/status.
CNT_W, 16, watchdog counter width.
TIMEOUT_CYCLES, 1000, max cycles a phase may stay in RUN; 0 disables the watchdog; must be < 2**CNT_W.
AUTO_START0, 1, 1 = phase 0 starts without start_req[0].

Ports:
clock  in  1  single system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
restart  in  1  synchronous return to phase 0 from any state.
start_req  in  NUM_PHASES  per-phase begin request (level or pulse).
end_done  in  NUM_PHASES  per-phase completion (level, sampled).
grant  out  NUM_PHASES  one-hot enable of the running phase.
leds  out  NUM_PHASES+1  thermometer progress; leds[i]=1 iff phase index >= i, or leds[0] in any non-reset state.
status  out  IDX_W  current phase index; NUM_PHASES = all done.
busy  out  1  a phase is in RUN.
done  out  1  all phases complete.
error  out  1  sequencer halted on a fault.
err_code  out  2  00 none, 01 timeout, 10 order violation, held until restart.

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0) values: status=0, grant=0, leds=0, busy=0, done=0, error=0, err_code=00, pending=0, counter=0, sub-state=WAIT_START.
- First clock edge after reset release: leds[0]=1.
- Sub-states: WAIT_START, RUN, DONE, ERROR; phase index k.
- pending[j]: sticky flag, set when start_req[j]=1 for j>k. Cleared when phase j enters RUN, or on restart.
- WAIT_START(k):
  - If start_req[k], pending[k], or (k=0 and AUTO_START0), go to RUN next edge.
  - On entering RUN: grant[k]=1, busy=1, counter=0.
  - end_done[k] is ignored in WAIT_START.
- RUN(k):
  - Counter increments each cycle.
  - If end_done[k]=1 at an edge: grant[k]=0 and k=k+1 at that same edge.
  - If the new k<NUM_PHASES and (pending[k] or start_req[k]): enter RUN(k) directly, with grant[k]=1 on the same edge (zero-gap handoff). Otherwise go to WAIT_START(k).
  - If the new k==NUM_PHASES: go to DONE, with done=1, busy=0, all leds=1.
- Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES while in RUN with end_done[k]=0, go to ERROR with err_code=01.
  - If end_done[k] arrives on the same edge the limit is reached, completion wins.
- Order violation: end_done[j]=1 for any j>k while in WAIT_START or RUN goes to ERROR with err_code=10. This takes priority over completion and timeout in the same cycle.
  - end_done[j] for j<k is ignored (held-high levels are legal).
- ERROR: grant=0, busy=0, error=1. status and leds freeze at the faulting phase. All inputs except restart are ignored.
- DONE: terminal; inputs are ignored except restart.
- restart=1 at an edge in any state: status=0, sub-state=WAIT_START, pending=0, error=0, err_code=00, done=0, grant=0, leds=...001, counter=0. restart takes priority over all events.
  - With AUTO_START0=1, RUN(0) follows one cycle later.
- reset_n asserted mid-RUN: all outputs clear immediately (asynchronously), without waiting for a clock edge.

Decomposition:
- Shared package phase_seq_pkg: sub-state enum (WAIT_START, RUN, DONE, ERROR), err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_ORDER).
- Sub-module phase_watchdog: counter with clear/enable and a "limit reached" flag; parameters CNT_W and TIMEOUT_CYCLES. Instantiated once and shared, since only one phase runs at a time.

Test Plan:
All scenarios use NUM_PHASES=3, TIMEOUT_CYCLES=8, AUTO_START0=1.
1. Release reset, hold start_req[1], end_done[0] at cycle 4, start_req[2] at cycle 6, end_done[1] at 7, end_done[2] at 9 -> grant goes 001 -> 010 (zero gap) -> 100; status 0->1->2->3; leds 0001->0011->0111->1111; done=1 after cycle 9.
2. Pulse start_req[2] for one cycle during phase 0 -> pending[2] held; on end_done[1], grant[2] asserts on the same edge grant[1] drops.
3. Phase 1 in RUN, no end_done for 8 cycles -> error=1, err_code=01, grant=000, status=1, leds=0011 frozen; then pulse restart -> status=0, error=0, grant=001 one cycle later.
4. In phase 0, assert end_done[2] -> ERROR, err_code=10. Also assert end_done[2] together with end_done[0] in the same cycle -> err_code=10 (order check has priority).
5. end_done[1] arrives on exactly the 8th RUN cycle of phase 1 -> advances to phase 2, no error.
6. Assert reset_n=0 mid-phase 2 between clock edges -> all outputs 0 immediately. Release -> sequence restarts at phase 0 with pending cleared.
